vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing: pixel-clock enable, h_counter/v_counter, sync pulses, active-video flag.
- Sits directly upstream of the screen/pixel generators (victory screen, game screens), which decode h_counter/v_counter combinationally into R/G/B.
- Takes their colour back and drives the DAC-facing pins through one register stage, with blanking applied.

---
 rtl/vga_timing_gen.sv | 253 +++++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 Hz VGA raster timing generator. Divides the system
//               clock into a pixel enable, runs the horizontal/vertical raster
//               counters, decodes the active-video window and drives the
//               DAC-facing pins through one aligned register stage with
//               blanking applied.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: VGA_FRAME_COUNT_EN
//    When defined, adds an 8-bit free-running frame counter output
//    (frame_count) that increments with every frame_start pulse.
// ----------------------------------------------------------------------------
// Ports:
//    clk          in   1  system clock
//    reset        in   1  synchronous, active-high reset
//    h_counter    out 10  current pixel column, 0..H_TOTAL-1
//    v_counter    out 10  current line, 0..V_TOTAL-1
//    video_on     out  1  current counters lie in the visible area
//    pix_tick     out  1  one-clk pixel enable, period CLK_DIV
//    frame_start  out  1  one-clk pulse when the raster wraps to (0,0)
//    R_in/G_in/B_in in 8  colour for the current counters
//    VGA_R/G/B    out  8  registered, blanked colour
//    VGA_HS       out  1  registered hsync, active low
//    VGA_VS       out  1  registered vsync, active low
//    VGA_BLANK_N  out  1  registered video_on
//    VGA_CLK      out  1  registered pix_tick
//    frame_count  out  8  frame counter (only with VGA_FRAME_COUNT_EN)
// ============================================================================
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] h_counter,
   output logic [9:0] v_counter,
   output logic       video_on,
   output logic       pix_tick,
   output logic       frame_start,
   input  logic [7:0] R_in,
   input  logic [7:0] G_in,
   input  logic [7:0] B_in,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_CLK
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [7:0] frame_count
`endif
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // A divide-by-1 still needs a one-bit counter so the compare stays legal.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   // ------------------------------------------------------------------------
   // Stage-0 state: divider, pixel enable, raster counters, frame pulse
   // ------------------------------------------------------------------------
   logic [DIV_W-1:0] div_q,         div_d;
   logic             pix_tick_q,    pix_tick_d;
   logic [9:0]       h_q,           h_d;
   logic [9:0]       v_q,           v_d;
   logic             frame_start_q, frame_start_d;

   // ------------------------------------------------------------------------
   // Stage-1 state: DAC-facing pins
   // ------------------------------------------------------------------------
   logic [7:0]       r_q,           r_d;
   logic [7:0]       g_q,           g_d;
   logic [7:0]       b_q,           b_d;
   logic             hs_q,          hs_d;
   logic             vs_q,          vs_d;
   logic             blank_n_q,     blank_n_d;
   logic             vga_clk_q,     vga_clk_d;

   // ------------------------------------------------------------------------
   // Combinational decode of the current raster position
   // ------------------------------------------------------------------------
   logic line_end;
   logic frame_end;
   logic video_on_w;
   logic hsync_win;
   logic vsync_win;

   assign line_end   = (h_q == H_LAST);
   assign frame_end  = line_end && (v_q == V_LAST);
   assign video_on_w = (h_q < H_VIS) && (v_q < V_VIS);

   // Sync windows are decoded from the counter registers themselves, so they
   // always see post-wrap values and cannot glitch across a wrap.
   assign hsync_win  = (h_q >= HS_START) && (h_q <= HS_END);
   assign vsync_win  = (v_q >= VS_START) && (v_q <= VS_END);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      div_d         = div_q;
      pix_tick_d    = 1'b0;
      h_d           = h_q;
      v_d           = v_q;
      frame_start_d = 1'b0;

      // Divider wraps at CLK_DIV-1; the enable is registered so it appears in
      // the cycle after the terminal count.
      if (div_q == DIV_LAST) begin
         div_d      = '0;
         pix_tick_d = 1'b1;
      end else begin
         div_d      = div_q + DIV_ONE;
      end

      // Raster advances only on pixel-enable cycles. Line-end and frame-end
      // wraps take effect on the same edge.
      if (pix_tick_q) begin
         if (line_end) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d = '0;
            end else begin
               v_d = v_q + 10'd1;
            end
         end else begin
            h_d = h_q + 10'd1;
         end
      end

      // Raised on the wrap edge, so it is high in the first (0,0) cycle.
      frame_start_d = pix_tick_q && frame_end;
   end

   always_comb begin
      r_d       = 8'h00;
      g_d       = 8'h00;
      b_d       = 8'h00;
      hs_d      = ~hsync_win;
      vs_d      = ~vsync_win;
      blank_n_d = video_on_w;
      vga_clk_d = pix_tick_q;

      if (video_on_w) begin
         r_d = R_in;
         g_d = G_in;
         b_d = B_in;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q         <= '0;
         pix_tick_q    <= 1'b0;
         h_q           <= '0;
         v_q           <= '0;
         frame_start_q <= 1'b0;
         r_q           <= 8'h00;
         g_q           <= 8'h00;
         b_q           <= 8'h00;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_n_q     <= 1'b0;
         vga_clk_q     <= 1'b0;
      end else begin
         div_q         <= div_d;
         pix_tick_q    <= pix_tick_d;
         h_q           <= h_d;
         v_q           <= v_d;
         frame_start_q <= frame_start_d;
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
         vga_clk_q     <= vga_clk_d;
      end
   end

   // ------------------------------------------------------------------------
   // Optional frame counter for screen blink/animation
   // ------------------------------------------------------------------------
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frame_count_q, frame_count_d;

   always_comb begin
      frame_count_d = frame_count_q;
      if (frame_start_d) begin
         frame_count_d = frame_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count_q <= 8'h00;
      end else begin
         frame_count_q <= frame_count_d;
      end
   end

   assign frame_count = frame_count_q;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign h_counter   = h_q;
   assign v_counter   = v_q;
   assign video_on    = video_on_w;
   assign pix_tick    = pix_tick_q;
   assign frame_start = frame_start_q;
   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_CLK     = vga_clk_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Uses a reduced raster
//               so several frames fit in a short run; expected values come
//               from closed-form arithmetic on the number of clock edges
//               since reset was last released.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   localparam int D   = 2;
   localparam int HV  = 20;
   localparam int HF  = 4;
   localparam int HS  = 6;
   localparam int HB  = 5;
   localparam int VV  = 10;
   localparam int VF  = 2;
   localparam int VS  = 2;
   localparam int VB  = 3;
   localparam int HT  = HV + HF + HS + HB;
   localparam int VT  = VV + VF + VS + VB;
   localparam int FR  = HT * VT;

   logic       clk;
   logic       reset;
   logic [9:0] h_counter;
   logic [9:0] v_counter;
   logic       video_on;
   logic       pix_tick;
   logic       frame_start;
   logic [7:0] R_in;
   logic [7:0] G_in;
   logic [7:0] B_in;
   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic       VGA_CLK;
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frame_count;
`endif

   vga_timing_gen #(
      .CLK_DIV   (D),
      .H_VISIBLE (HV),
      .H_FRONT   (HF),
      .H_SYNC    (HS),
      .H_BACK    (HB),
      .V_VISIBLE (VV),
      .V_FRONT   (VF),
      .V_SYNC    (VS),
      .V_BACK    (VB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .h_counter   (h_counter),
      .v_counter   (v_counter),
      .video_on    (video_on),
      .pix_tick    (pix_tick),
      .frame_start (frame_start),
      .R_in        (R_in),
      .G_in        (G_in),
      .B_in        (B_in),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_BLANK_N (VGA_BLANK_N),
      .VGA_CLK     (VGA_CLK)
`ifdef VGA_FRAME_COUNT_EN
      ,
      .frame_count (frame_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   int         n      = 0;     // edges since reset was last released
   bit         const_ff = 1'b0;
   logic [7:0] prev_r, prev_g, prev_b;

   // ---------------- reference model (function of edge count) -------------
   // Pixel periods completed after k edges: first enable appears D edges in.
   function automatic int ticks(input int k);
      return (k >= 1) ? (k - 1) / D : 0;
   endfunction

   function automatic bit ptick(input int k);
      return (k > 0) && (k % D == 0);
   endfunction

   function automatic int h_of(input int k);
      return ticks(k) % HT;
   endfunction

   function automatic int v_of(input int k);
      return (ticks(k) / HT) % VT;
   endfunction

   function automatic bit von(input int k);
      return (h_of(k) < HV) && (v_of(k) < VV);
   endfunction

   function automatic bit fstart(input int k);
      return (k >= 2) && ptick(k - 1) && (ticks(k) % FR == 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   // Advance one clock, check every output against the model, then drive
   // fresh colour for the next edge.
   task automatic step();
      bit r;
      int k;
      r = reset;
      @(posedge clk);
      #1;
      if (r) n = 0;
      else   n = n + 1;
      prev_r = R_in;
      prev_g = G_in;
      prev_b = B_in;

      chk("h_counter",   32'(h_counter),   32'(h_of(n)));
      chk("v_counter",   32'(v_counter),   32'(v_of(n)));
      chk("video_on",    32'(video_on),    32'(von(n)));
      chk("pix_tick",    32'(pix_tick),    32'(ptick(n)));
      chk("frame_start", 32'(frame_start), 32'(fstart(n)));
`ifdef VGA_FRAME_COUNT_EN
      chk("frame_count", 32'(frame_count), 32'((ticks(n) / FR) % 256));
`endif
      if (n == 0) begin
         chk("VGA_R_rst",   32'(VGA_R),       32'h0);
         chk("VGA_G_rst",   32'(VGA_G),       32'h0);
         chk("VGA_B_rst",   32'(VGA_B),       32'h0);
         chk("VGA_HS_rst",  32'(VGA_HS),      32'h1);
         chk("VGA_VS_rst",  32'(VGA_VS),      32'h1);
         chk("BLANK_N_rst", 32'(VGA_BLANK_N), 32'h0);
         chk("VGA_CLK_rst", 32'(VGA_CLK),     32'h0);
      end else begin
         k = n - 1;
         chk("VGA_R",   32'(VGA_R), von(k) ? 32'(prev_r) : 32'h0);
         chk("VGA_G",   32'(VGA_G), von(k) ? 32'(prev_g) : 32'h0);
         chk("VGA_B",   32'(VGA_B), von(k) ? 32'(prev_b) : 32'h0);
         chk("VGA_HS",  32'(VGA_HS),
             ((h_of(k) >= HV + HF) && (h_of(k) < HV + HF + HS)) ? 32'h0 : 32'h1);
         chk("VGA_VS",  32'(VGA_VS),
             ((v_of(k) >= VV + VF) && (v_of(k) < VV + VF + VS)) ? 32'h0 : 32'h1);
         chk("BLANK_N", 32'(VGA_BLANK_N), 32'(von(k)));
         chk("VGA_CLK", 32'(VGA_CLK),     32'(ptick(k)));
      end

      R_in = const_ff ? 8'hFF : 8'($urandom);
      G_in = const_ff ? 8'hFF : 8'($urandom);
      B_in = const_ff ? 8'hFF : 8'($urandom);
   endtask

   initial begin
      int hs_low;
      int vs_low;
      int fs_cnt;
      bit found;

      reset = 1'b1;
      R_in  = 8'($urandom);
      G_in  = 8'($urandom);
      B_in  = 8'($urandom);

      // Reset held for three clocks.
      repeat (3) step();
      reset = 1'b0;

      // Two and a bit frames of random colour from a clean start.
      repeat (2 * FR * D + 150) step();

      // Steady-state window of exactly one frame: sync widths and one pulse.
      hs_low = 0;
      vs_low = 0;
      fs_cnt = 0;
      for (int i = 0; i < FR * D; i++) begin
         step();
         if (VGA_HS == 1'b0) hs_low++;
         if (VGA_VS == 1'b0) vs_low++;
         if (frame_start)    fs_cnt++;
      end
      chk("hs_low_clks", 32'(hs_low), 32'(VT * HS * D));
      chk("vs_low_clks", 32'(vs_low), 32'(VS * HT * D));
      chk("fs_per_frame", 32'(fs_cnt), 32'd1);

      // Mid-frame reset for one clock at a mid-screen position.
      found = 1'b0;
      for (int i = 0; i < FR * D + 10; i++) begin
         if ((h_of(n) == HV / 2) && (v_of(n) == VV / 2)) begin
            found = 1'b1;
            break;
         end
         step();
      end
      if (!found) begin
         checks++;
         errors++;
         $error("FAIL midframe_seek: observed no target position expected h=%0d v=%0d", HV / 2, VV / 2);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;

      // Full-white input: visible-area corners pass, blanking region is black.
      const_ff = 1'b1;
      R_in = 8'hFF;
      G_in = 8'hFF;
      B_in = 8'hFF;
      repeat (FR * D + 20) step();
      const_ff = 1'b0;

      // Random colour with occasional random-length resets anywhere.
      for (int i = 0; i < 3 * FR * D; i++) begin
         if (!reset && ($urandom_range(0, 499) == 0)) reset = 1'b1;
         else if (reset && ($urandom_range(0, 2) == 0)) reset = 1'b0;
         step();
      end
      reset = 1'b0;
      repeat (D * HT) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
